// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters,
// zero-latency fetch lookup, EX-stage resolve/redirect and statistics counters.
module branch_predict_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter bit          PRED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    // Reject table depths that are not a power of two or smaller than 2
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predict_unit: ENTRIES must be a power of two >= 2");
    end

    // BTB storage, one packed slot per entry
    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0]            jump_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][XLEN-1:0]  target_q;
    logic [ENTRIES-1:0][1:0]       ctr_q;

    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    // Fetch-side lookup signals
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    // Execute-side resolve signals
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             cf;
    logic             is_jump;
    logic             actual_taken;
    logic             upd_en;

    // Next contents of the slot addressed by ex_pc
    logic             upd_we;
    logic [XLEN-1:0]  nxt_target;
    logic             nxt_jump;
    logic [1:0]       nxt_ctr;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    // Zero-latency lookup; reads registered contents so a same-cycle update is not seen
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = PRED_EN && if_valid && if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
        pred_target = pred_taken ? target_q[if_idx] : (if_pc + XLEN'(4));
    end

    // Resolve the EX-stage control-flow instruction and decide the redirect
    always_comb begin
        cf           = ex_is_branch || ex_is_jal || ex_is_jalr;
        is_jump      = ex_is_jal || ex_is_jalr;
        actual_taken = ex_branch_taken || is_jump;
        upd_en       = ex_valid && cf;
        ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        redirect     = upd_en && ((actual_taken != ex_pred_taken) ||
                                  (actual_taken && (ex_branch_target != ex_pred_target)));
        redirect_pc  = actual_taken ? ex_branch_target : (ex_pc + XLEN'(4));
    end

    // Compute the new slot contents: train on a hit, allocate on a taken miss
    always_comb begin
        upd_we     = 1'b0;
        nxt_target = target_q[ex_idx];
        nxt_jump   = jump_q[ex_idx];
        nxt_ctr    = ctr_q[ex_idx];
        if (upd_en) begin
            if (ex_hit) begin
                upd_we = 1'b1;
                if (is_jump) begin
                    nxt_ctr    = 2'b11;
                    nxt_jump   = 1'b1;
                    nxt_target = ex_branch_target;
                end else if (ex_branch_taken) begin
                    nxt_ctr    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : (ctr_q[ex_idx] + 2'd1);
                    nxt_target = ex_branch_target;
                end else begin
                    nxt_ctr    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : (ctr_q[ex_idx] - 2'd1);
                end
            end else if (actual_taken) begin
                upd_we     = 1'b1;
                nxt_target = ex_branch_target;
                nxt_jump   = is_jump;
                nxt_ctr    = is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // BTB table write; reset invalidates every slot and sets weakly-not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            jump_q   <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{2'b01}};
        end else if (upd_we) begin
            valid_q[ex_idx]  <= 1'b1;
            jump_q[ex_idx]   <= nxt_jump;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= nxt_target;
            ctr_q[ex_idx]    <= nxt_ctr;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (upd_en && (branch_count_q != 32'hFFFF_FFFF)) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (redirect && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC and target width.
REQ-002 Parameter ENTRIES, default 16, SHALL set the BTB depth; it SHALL be a power of two and at least 2; IDX_W = log2(ENTRIES).
REQ-003 Parameter PRED_EN, default 1, SHALL enable prediction; when 0, pred_taken SHALL be held 0 and the table SHALL still update.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port if_valid, input, 1 bit: the IF-stage lookup request is valid.
REQ-007 Port if_pc, input, XLEN bits: the fetch PC.
REQ-008 Port pred_taken, output, 1 bit: the predicted-taken flag for if_pc.
REQ-009 Port pred_target, output, XLEN bits: the predicted next PC.
REQ-010 Port ex_valid, input, 1 bit: the EX-stage instruction is valid.
REQ-011 Port ex_pc, input, XLEN bits: the PC of the EX-stage instruction.
REQ-012 Ports ex_is_branch, ex_is_jal, ex_is_jalr, input, 1 bit each: instruction class; at most one SHALL be high.
REQ-013 Port ex_branch_taken, input, 1 bit: the resolved taken flag.
REQ-014 Port ex_branch_target, input, XLEN bits: the resolved target.
REQ-015 Port ex_pred_taken, input, 1 bit: the prediction made at fetch, piped to EX.
REQ-016 Port ex_pred_target, input, XLEN bits: the predicted target made at fetch, piped to EX.
REQ-017 Port redirect, output, 1 bit: the mispredict flush/redirect request.
REQ-018 Port redirect_pc, output, XLEN bits: the corrected fetch PC.
REQ-019 Port branch_count, output, 32 bits: the number of resolved control-flow instructions.
REQ-020 Port mispredict_count, output, 32 bits: the number of mispredicts.

Function
REQ-021 Each BTB entry SHALL hold: valid, tag = pc[XLEN-1:IDX_W+2], target (XLEN bits), jump bit, and a 2-bit saturating counter; the entry index SHALL be pc[IDX_W+1:2].
REQ-022 Lookup SHALL be combinational with zero latency; hit = valid AND tag match at the if_pc index.
REQ-023 pred_taken SHALL equal PRED_EN AND if_valid AND hit AND (jump bit OR counter[1]).
REQ-024 pred_target SHALL be the entry target when pred_taken = 1, otherwise if_pc + 4, computed modulo 2^XLEN.
REQ-025 The resolved flag actual_taken SHALL be ex_branch_taken OR ex_is_jal OR ex_is_jalr.
REQ-026 redirect SHALL be combinational and SHALL equal ex_valid AND cf AND (actual_taken != ex_pred_taken OR (actual_taken AND ex_branch_target != ex_pred_target)), where cf = ex_is_branch OR ex_is_jal OR ex_is_jalr.
REQ-027 redirect_pc SHALL be ex_branch_target when actual_taken = 1, otherwise ex_pc + 4 (wrapping); its value SHALL be don't-care when redirect = 0.
REQ-028 With ex_valid AND cf and a hit at the ex_pc index, the entry SHALL be updated on the next clock edge as follows:
- conditional branch: counter +1 saturating at 3 if taken, -1 saturating at 0 if not taken; target written when taken;
- JAL/JALR: counter set to 3, jump bit set, target written.
REQ-029 With ex_valid AND cf, a miss, and actual_taken = 1, the unit SHALL allocate, overwriting any valid entry at that index: valid = 1, tag, target, jump bit = ex_is_jal OR ex_is_jalr, counter = 2 for a branch or 3 for a jump.
REQ-030 A not-taken branch that misses SHALL NOT allocate.
REQ-031 When a lookup and an update address the same index in the same cycle, the lookup SHALL see the pre-update contents (no bypass).
REQ-032 branch_count SHALL increment once per cycle in which ex_valid AND cf is true.
REQ-033 mispredict_count SHALL increment once per cycle in which redirect is true.
REQ-034 branch_count and mispredict_count SHALL saturate at 32'hFFFF_FFFF.
REQ-035 When ex_valid = 0, no table or counter state SHALL change.

Reset
REQ-036 When rst_n is low, all valid bits SHALL clear, all counters SHALL be set to 2'b01, all jump bits SHALL clear, and branch_count and mispredict_count SHALL be 0, asynchronously.
REQ-037 After reset, every lookup SHALL miss, so pred_taken = 0 and pred_target = if_pc + 4.
REQ-038 Reset asserted mid-update SHALL discard that update; the first update SHALL occur on the first rising edge with rst_n high.

Verification
REQ-039 Cold miss: after reset, apply if_pc = 0x100 -> required pred_taken = 0 and pred_target = 0x104.
REQ-040 Allocate: apply a taken branch at ex_pc = 0x100 with target 0x180 and ex_pred_taken = 0 -> required redirect = 1 and redirect_pc = 0x180; on the next cycle, if_pc = 0x100 SHALL give pred_taken = 1 and pred_target = 0x180, and mispredict_count SHALL be 1.
REQ-041 Hysteresis: after the allocate scenario, resolve the branch at 0x100 not-taken once -> required counter = 1 and pred_taken = 0; resolve it taken twice -> required counter = 3 and pred_taken = 1; resolve it not-taken once -> required pred_taken still 1.
REQ-042 Target mismatch: apply a JALR at 0x200, predicted taken to 0x300, resolved to 0x340 -> required redirect = 1, redirect_pc = 0x340, and the entry target rewritten to 0x340.
REQ-043 Aliasing: with ENTRIES = 16, allocate PCs 0x100 and 0x140 (same index, different tag) -> required: the second allocation evicts the first, and if_pc = 0x100 then misses.
REQ-044 Saturation and reset: force branch_count to 0xFFFFFFFF and resolve one more branch -> required branch_count holds at 0xFFFFFFFF; pulse rst_n low -> required counters = 0 and all lookups miss.
